// File: rtl/rx_burst_sink_pkg.sv
// rx_pkg: shared checker state encoding and default widths for rx_burst_sink
package rx_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
endpackage

// File: rtl/rx_burst_sink_sync_fifo.sv
// sync_fifo: single-clock FIFO, no bypass, storage cleared on reset
//   clk, rst_n        clock, async active-low reset
//   push, push_data   write request (ignored when full) and word
//   pop               read request (ignored when empty)
//   pop_data          word at the read pointer
//   full, empty       occupancy flags
//   count             words held, wr_ptr - rd_ptr
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_q, rd_q;
  logic              do_push, do_pop;
  assign count    = wr_q - rd_q;
  assign full     = count == (AW+1)'(DEPTH);
  assign empty    = count == '0;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
endmodule

// File: rtl/rx_burst_sink.sv
// rx_burst_sink: checks incoming bursts against the 1..BURST_LEN ramp and buffers them
//   clk, rst_n                    clock, async active-low reset
//   data, valid, ready            upstream stream
//   m_data, m_valid, m_ready      downstream FIFO port
//   seq_err, short_burst          one-cycle pulses after the offending edge
//   burst_done                    high during the cycle after the last word of a burst
//   burst_cnt, err_cnt            closed bursts (wraps), sequence errors (saturates)
module rx_burst_sink #(
  parameter int DATA_W    = rx_pkg::DATA_W,
  parameter int DEPTH     = 8,
  parameter int BURST_LEN = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       data,
  input  logic                    valid,
  output logic                    ready,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    seq_err,
  output logic                    short_burst,
  output logic                    burst_done,
  output logic [rx_pkg::CNT_W-1:0] burst_cnt,
  output logic [rx_pkg::CNT_W-1:0] err_cnt
);
  import rx_pkg::*;
  localparam int IW = $clog2(BURST_LEN + 1);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t           state_q;
  logic [IW-1:0]    idx_q, idx_nxt;
  logic [CNT_W-1:0] burst_cnt_q, err_cnt_q;
  logic             seq_err_q, short_q, done_q;
  logic             acc, mismatch, close_short, close_burst, fifo_empty, fifo_full_unused;
  logic [CW-1:0]    fifo_count;
  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (acc),
    .push_data (data),
    .pop       (m_ready),
    .pop_data  (m_data),
    .full      (fifo_full_unused),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
  assign ready       = (fifo_count < CW'(DEPTH)) && (state_q != DONE);
  assign acc         = valid && ready;
  // idx is 0 in IDLE, so idx+1 is the expected word in both IDLE and RECV
  assign idx_nxt     = idx_q + IW'(1);
  assign mismatch    = data != DATA_W'(idx_nxt);
  assign close_short = (state_q == RECV) && !valid;
  assign close_burst = close_short || (state_q == DONE);
  assign m_valid     = !fifo_empty;
  assign seq_err     = seq_err_q;
  assign short_burst = short_q;
  assign burst_done  = done_q;
  assign burst_cnt   = burst_cnt_q;
  assign err_cnt     = err_cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      seq_err_q   <= 1'b0;
      short_q     <= 1'b0;
      done_q      <= 1'b0;
      burst_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      seq_err_q <= acc && mismatch;
      short_q   <= close_short;
      done_q    <= acc && (idx_nxt == IW'(BURST_LEN));
      if (acc && mismatch && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      if (close_burst) burst_cnt_q <= burst_cnt_q + 1'b1;
      if (close_burst) begin
        state_q <= IDLE;
        idx_q   <= '0;
      end else if (acc) begin
        idx_q   <= idx_nxt;
        state_q <= (idx_nxt == IW'(BURST_LEN)) ? DONE : RECV;
      end
    end
endmodule
